// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the PC_FD/FD datapath: latches the fetched word into IR and
// sequences LW/SW/ADD/SUB/ADDI/BEQ through FETCH/DECODE/EXEC/MEM/WB.
module uc_multiciclo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic        inc,
  output logic        load,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic        WE_reg,
  output logic        WE_mem,
  output logic        OP_MEM,
  output logic        ADD_SUB,
  output logic [31:0] OFFSET,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  state_t      state_q;
  logic [31:0] ir_q;
  logic        done_q;
  logic        illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_legal;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  assign is_add   = (opcode == OP_R)    && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = (opcode == OP_R)    && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi  = (opcode == OP_I)    && (funct3 == 3'b000);
  assign is_lw    = (opcode == OP_LOAD) && (funct3 == 3'b010);
  assign is_sw    = (opcode == OP_STOR) && (funct3 == 3'b010);
  assign is_beq   = (opcode == OP_BR)   && (funct3 == 3'b000);
  assign is_legal = is_add | is_sub | is_addi | is_lw | is_sw | is_beq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:   if (start) state_q <= S_FETCH;
        S_FETCH: begin
          if (halt) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            ir_q    <= instruction;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_q <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_ERROR;
          end
        end
        S_EXEC: begin
          if (is_beq)              state_q <= S_FETCH;
          else if (is_lw || is_sw) state_q <= S_MEM;
          else                     state_q <= S_WB;
        end
        S_MEM:    state_q <= is_lw ? S_WB : S_FETCH;
        S_WB:     state_q <= S_FETCH;
        S_ERROR:  state_q <= S_ERROR;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign Ra      = ir_q[19:15];
  assign Rb      = ir_q[24:20];
  assign Rw      = ir_q[11:7];
  assign busy    = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign done    = done_q;
  assign illegal = illegal_q;

  // Immediate format follows the opcode; R-type and unknown opcodes yield zero.
  always_comb begin
    OFFSET = '0;
    case (opcode)
      OP_I, OP_LOAD: OFFSET = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STOR:       OFFSET = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BR:         OFFSET = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default:       OFFSET = '0;
    endcase
  end

  always_comb begin
    inc     = 1'b0;
    load    = 1'b0;
    WE_reg  = 1'b0;
    WE_mem  = 1'b0;
    OP_MEM  = 1'b0;
    ADD_SUB = 1'b0;
    case (state_q)
      S_EXEC: begin
        ADD_SUB = is_sub | is_beq;
        load    = is_beq & zero;
        inc     = is_beq & ~zero;
      end
      S_MEM: begin
        OP_MEM = is_lw;
        WE_mem = is_sw;
        inc    = is_sw;
      end
      S_WB: begin
        WE_reg = (Rw != 5'd0);
        inc    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo; outputs are sampled on the falling edge.
module tb_uc_multiciclo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic        inc, load, WE_reg, WE_mem, OP_MEM, ADD_SUB, busy, done, illegal;
  logic [4:0]  Ra, Rb, Rw;
  logic [31:0] OFFSET;

  int vectors = 0;
  int miscompares = 0;

  uc_multiciclo dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .instruction(instruction), .zero(zero),
    .inc(inc), .load(load), .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .WE_reg(WE_reg), .WE_mem(WE_mem), .OP_MEM(OP_MEM), .ADD_SUB(ADD_SUB),
    .OFFSET(OFFSET), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Bit order: inc load WE_reg WE_mem OP_MEM ADD_SUB busy done illegal
  function automatic logic [8:0] strobes();
    return {inc, load, WE_reg, WE_mem, OP_MEM, ADD_SUB, busy, done, illegal};
  endfunction

  // Resets, then starts the unit; returns at the falling edge of the first FETCH cycle.
  task automatic go(input logic [31:0] ins);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    start = 1'b1;
    instruction = ins;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (strobes() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got %b want %b", strobes(), 9'b0);
    end
    vectors++;
    if ({Ra, Rb, Rw, OFFSET} !== 47'd0) begin
      miscompares++;
      $display("FAIL reset_fields got Ra=%0d Rb=%0d Rw=%0d OFFSET=%h want all 0", Ra, Rb, Rw, OFFSET);
    end
    reset = 1'b0;
  endtask

  // ADD then SUB back to back, then a halt in the next FETCH.
  task automatic test_add_sub();
    logic [8:0] exp [1:8];
    exp = '{9'b000000100, 9'b000000100, 9'b000000100, 9'b101000100,
            9'b000000100, 9'b000000100, 9'b000001100, 9'b101000100};
    go(32'h002081B3);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) instruction = 32'h402081B3;
      vectors++;
      if (strobes() !== exp[c]) begin
        miscompares++;
        $display("FAIL add_sub_c%0d strobes got %b want %b", c, strobes(), exp[c]);
      end
      if (c == 2 || c == 6) begin
        vectors++;
        if ({Ra, Rb, Rw, OFFSET} !== {5'd1, 5'd2, 5'd3, 32'd0}) begin
          miscompares++;
          $display("FAIL add_sub_fields_c%0d got Ra=%0d Rb=%0d Rw=%0d OFFSET=%h want 1 2 3 0",
                   c, Ra, Rb, Rw, OFFSET);
        end
      end
      @(negedge clk);
    end
    halt = 1'b1;
    vectors++;
    if (strobes() !== 9'b000000100) begin
      miscompares++;
      $display("FAIL halt_fetch got %b want %b", strobes(), 9'b000000100);
    end
    @(negedge clk) halt = 1'b0;
    vectors++;
    if (strobes() !== 9'b000000010) begin
      miscompares++;
      $display("FAIL halt_done got %b want %b", strobes(), 9'b000000010);
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 9'b0) begin
      miscompares++;
      $display("FAIL halt_idle got %b want %b", strobes(), 9'b0);
    end
  endtask

  task automatic test_lw();
    logic [8:0] exp [1:6];
    exp = '{9'b000000100, 9'b000000100, 9'b000000100, 9'b000010100,
            9'b101000100, 9'b000000100};
    go(32'h0080A283);
    for (int c = 1; c <= 6; c++) begin
      vectors++;
      if (strobes() !== exp[c]) begin
        miscompares++;
        $display("FAIL lw_c%0d strobes got %b want %b", c, strobes(), exp[c]);
      end
      if (c == 2 || c == 5) begin
        vectors++;
        if ({Ra, Rw, OFFSET} !== {5'd1, 5'd5, 32'h00000008}) begin
          miscompares++;
          $display("FAIL lw_fields_c%0d got Ra=%0d Rw=%0d OFFSET=%h want 1 5 00000008",
                   c, Ra, Rw, OFFSET);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [8:0] exp [1:5];
    exp = '{9'b000000100, 9'b000000100, 9'b000000100, 9'b100100100, 9'b000000100};
    go(32'hFE20AE23);
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (strobes() !== exp[c]) begin
        miscompares++;
        $display("FAIL sw_c%0d strobes got %b want %b", c, strobes(), exp[c]);
      end
      if (c == 2) begin
        vectors++;
        if ({Ra, Rb, OFFSET} !== {5'd1, 5'd2, 32'hFFFFFFFC}) begin
          miscompares++;
          $display("FAIL sw_fields got Ra=%0d Rb=%0d OFFSET=%h want 1 2 FFFFFFFC", Ra, Rb, OFFSET);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [8:0] exp [0:1];
    exp = '{9'b100001100, 9'b010001100};
    for (int z = 0; z <= 1; z++) begin
      zero = z[0];
      go(32'h00208863);
      for (int c = 1; c <= 4; c++) begin
        vectors++;
        if (strobes() !== ((c == 3) ? exp[z] : 9'b000000100)) begin
          miscompares++;
          $display("FAIL beq_z%0d_c%0d strobes got %b want %b", z, c, strobes(),
                   (c == 3) ? exp[z] : 9'b000000100);
        end
        if (c == 2) begin
          vectors++;
          if (OFFSET !== 32'h00000010) begin
            miscompares++;
            $display("FAIL beq_offset got %h want 00000010", OFFSET);
          end
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_x0();
    logic [8:0] exp [1:5];
    exp = '{9'b000000100, 9'b000000100, 9'b000000100, 9'b100000100, 9'b000000100};
    go(32'h00508013);
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (strobes() !== exp[c]) begin
        miscompares++;
        $display("FAIL addi_x0_c%0d strobes got %b want %b", c, strobes(), exp[c]);
      end
      if (c == 2) begin
        vectors++;
        if ({Rw, OFFSET} !== {5'd0, 32'h00000005}) begin
          miscompares++;
          $display("FAIL addi_fields got Rw=%0d OFFSET=%h want 0 00000005", Rw, OFFSET);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    go(32'hFFFFFFFF);
    vectors++;
    if (strobes() !== 9'b000000100) begin
      miscompares++;
      $display("FAIL illegal_fetch got %b want %b", strobes(), 9'b000000100);
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      vectors++;
      if (strobes() !== 9'b000000001) begin
        miscompares++;
        $display("FAIL illegal_hold_c%0d got %b want %b", c, strobes(), 9'b000000001);
      end
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 9'b0) begin
      miscompares++;
      $display("FAIL illegal_reset got %b want %b", strobes(), 9'b0);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_start_halt();
    @(negedge clk);
    start = 1'b1;
    halt = 1'b1;
    @(negedge clk) start = 1'b0;
    vectors++;
    if (strobes() !== 9'b000000100) begin
      miscompares++;
      $display("FAIL start_halt_fetch got %b want %b", strobes(), 9'b000000100);
    end
    @(negedge clk) halt = 1'b0;
    vectors++;
    if (strobes() !== 9'b000000010) begin
      miscompares++;
      $display("FAIL start_halt_done got %b want %b", strobes(), 9'b000000010);
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 9'b0) begin
      miscompares++;
      $display("FAIL start_halt_idle got %b want %b", strobes(), 9'b0);
    end
  endtask

  task automatic test_reset_mid_sw();
    go(32'hFE20AE23);
    repeat (3) @(negedge clk);
    vectors++;
    if (WE_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_mem_before_reset got WE_mem=%b want 1", WE_mem);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_mid_sw got %b want %b", strobes(), 9'b0);
    end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (strobes() !== 9'b0) begin
        miscompares++;
        $display("FAIL after_reset_c%0d got %b want %b", c, strobes(), 9'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_lw();
    test_sw();
    test_beq();
    test_addi_x0();
    test_illegal();
    test_start_halt();
    test_reset_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit that sequences the PC_FD/FD datapath. It latches each fetched instruction into an internal IR and decodes the RV32I subset LW, SW, ADD, SUB, ADDI and BEQ. Per state, it drives the register-file addresses, the write enables, the memory and ALU controls, the sign-extended immediate, and the PC increment/load strobes. It sits beside PC_FD and FD at the processor top and replaces the hard-wired instruction slicing.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 5.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears state, IR and sticky flags
- start  in  1  leaves IDLE and begins fetching; sampled only in IDLE
- halt  in  1  stop request; sampled only in FETCH
- instruction  in  32  instruction word from PC_FD, valid in FETCH
- zero  in  1  FD comparator flag (doutA == doutB), sampled only in EXEC of BEQ
- inc  out  1  PC += 4 strobe, one cycle
- load  out  1  PC += OFFSET strobe (taken branch), one cycle
- Ra  out  5  IR[19:15]
- Rb  out  5  IR[24:20]
- Rw  out  5  IR[11:7]
- WE_reg  out  1  register-file write enable
- WE_mem  out  1  data-memory write enable
- OP_MEM  out  1  data-memory read enable (LW)
- ADD_SUB  out  1  ALU op: 0 = add, 1 = subtract
- OFFSET  out  32  sign-extended immediate for the current IR
- busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse on the halt exit FETCH -> IDLE
- illegal  out  1  sticky; high in ERROR

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR. Moore outputs come from registered state and IR; the only input-dependent path is zero -> load/inc in EXEC.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: if halt=1, assert done and go to IDLE; IR is unchanged. Otherwise IR <= instruction and go to DECODE.
- DECODE: Ra, Rb, Rw and OFFSET are valid. Legal opcode -> EXEC; otherwise -> ERROR.
- Legal encodings (opcode/funct3/funct7):
  - ADD: 0110011/000/0000000
  - SUB: 0110011/000/0100000
  - ADDI: 0010011/000
  - LW: 0000011/010
  - SW: 0100011/010
  - BEQ: 1100011/000
  - Any other combination is illegal.
- EXEC:
  - ADD/ADDI/LW/SW: ADD_SUB=0.
  - SUB/BEQ: ADD_SUB=1.
  - R/I-type -> WB. LW and SW -> MEM.
  - BEQ: zero=1 gives load=1, zero=0 gives inc=1; then -> FETCH.
- MEM:
  - LW: OP_MEM=1, then -> WB.
  - SW: WE_mem=1 and inc=1, then -> FETCH.
- WB: WE_reg=1 only if Rw != 0 (x0 is never written); inc=1; then -> FETCH.
- ERROR: illegal=1 and all strobes 0. Exit only by reset.
- OFFSET, all sign-extended from IR[31]:
  - I-type (ADDI, LW): IR[31:20].
  - S-type: {IR[31:25], IR[11:7]}.
  - B-type: {IR[31], IR[7], IR[30:25], IR[11:8], 1'b0}.
  - R-type: 0.
- Exactly one of inc/load is asserted per executed instruction. WE_reg, WE_mem and OP_MEM are mutually exclusive.

## Timing
- Reset values:
  - State IDLE, IR = 0, illegal = 0.
  - inc, load, WE_reg, WE_mem, OP_MEM, ADD_SUB, busy, done = 0.
  - Ra, Rb, Rw = 0; OFFSET = 0.
- Cycles per instruction, counted from entering FETCH:
  - ADD/SUB/ADDI: 4 (F, D, E, WB).
  - LW: 5 (F, D, E, M, WB).
  - SW: 4 (F, D, E, M).
  - BEQ: 3 (F, D, E).
- The next FETCH immediately follows the last state; there are no bubbles.
- The PC update happens in the final cycle, so the PC_FD output is valid in the next FETCH.
- start is ignored outside IDLE. halt is ignored outside FETCH; an instruction already in flight always completes.
- If start and halt are both high in IDLE, the unit goes to FETCH; in the following cycle halt is honoured (done pulses), giving zero instructions executed.
- Reset asserted mid-instruction: all outputs clear asynchronously and no partial write completes after reset release.

## Test plan
- Reset then start with instruction=0x002081B3 (ADD x3,x1,x2):
  - Ra=1, Rb=2, Rw=3, ADD_SUB=0.
  - WE_reg=1 and inc=1 in cycle 4 only.
  - Repeat with 0x402081B3: ADD_SUB=1.
- 0x0080A283 (LW x5,8(x1)):
  - OFFSET=0x00000008.
  - OP_MEM=1 in cycle 4; WE_reg=1 with Rw=5 and inc=1 in cycle 5.
- 0xFE20AE23 (SW x2,-4(x1)):
  - OFFSET=0xFFFFFFFC.
  - WE_mem=1 and inc=1 in cycle 4; WE_reg never asserted.
- 0x00208863 (BEQ x1,x2,+16):
  - OFFSET=0x00000010.
  - zero=1 -> load=1 in cycle 3; zero=0 -> inc=1 in cycle 3.
- 0xFFFFFFFF -> DECODE -> ERROR; illegal=1 and busy=0 persist. Only reset clears them.
- ADDI with Rw=0 -> no WE_reg, but inc=1.
- halt=1 in FETCH -> done pulse for 1 cycle, then IDLE.
- Reset pulsed during MEM of SW -> WE_mem=0 immediately.
